// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: mid-bit sampling, start-glitch rejection,
// framing-error flag and break recovery before the next frame is accepted.
module uart_receiver #(
  parameter int unsigned clks_per_bit = 51
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = 14;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((clks_per_bit - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       sh;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= 2'b11;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // line went high again before mid-start: a glitch, not a frame
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            sh[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              dout    <= sh;
              valid   <= 1'b1;
              rx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // hold off until the line recovers so a break is not read as frames
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
